// File: rtl/sr_write_driver.sv
// sr_write_driver: write front-end for the SR-latch storage array.
// Sends a set/reset pulse to one word, lets it settle, then checks the readback.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   REQ_VALID/READY     write request handshake
//   REQ_ADDR, REQ_DATA  target word and value (sampled on accept)
//   S, R                set/reset lines, bit [a*DATA_W+i] = latch i of word a
//   Q                   latch outputs fed back from the array
//   DONE, ERR           completion pulse; ERR=1 flags a readback mismatch
module sr_write_driver #(
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             REQ_VALID,
  output logic                             REQ_READY,
  input  logic [ADDR_W-1:0]                REQ_ADDR,
  input  logic [DATA_W-1:0]                REQ_DATA,
  output logic [(2**ADDR_W)*DATA_W-1:0]    S,
  output logic [(2**ADDR_W)*DATA_W-1:0]    R,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    Q,
  output logic                             DONE,
  output logic                             ERR
);

  localparam int WORDS = 2**ADDR_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PULSE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_VERIFY = 2'd3;

  localparam logic [3:0] PULSE_LD  = 4'(PULSE_CYC - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] q_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          addr_d  = REQ_ADDR;
          data_d  = REQ_DATA;
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_VERIFY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // S/R come only from registered state, so S and R are complementary
  // on one slice during PULSE and all-zero otherwise.
  always_comb begin
    S     = '0;
    R     = '0;
    q_sel = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (addr_q == ADDR_W'(w)) begin
        q_sel = Q[w*DATA_W +: DATA_W];
        if (state_q == ST_PULSE) begin
          S[w*DATA_W +: DATA_W] = data_q;
          R[w*DATA_W +: DATA_W] = ~data_q;
        end
      end
    end
  end

  assign REQ_READY = (state_q == ST_IDLE);
  assign DONE      = (state_q == ST_VERIFY);
  assign ERR       = DONE && (q_sel != data_q);

endmodule

// File: doc/sr_write_driver.md
# sr_write_driver

Synchronous write front-end for the latch-based storage array. Accepts one write request at a time over a valid/ready handshake and drives the S/R inputs of the addressed word's SR-latch bit cells with a fixed-width set/reset pulse. It then idles S/R through a settle window and checks the latch Q outputs against the written data. It sits directly upstream of the sr_latch array: every S and R of the array comes from this block, and the array's Q bus feeds back into it.

## Interface

- ADDR_W, 2, word address width; WORDS = 2**ADDR_W.
- DATA_W, 4, bits per word (latches per word).
- PULSE_CYC, 2, cycles S/R are held active per write; legal range 1..15.
- SETTLE_CYC, 1, cycles S/R are held all-zero before verify; legal range 1..15.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-high reset. This is the block's only clock domain: one clock, reset synchronous and active-high.
- REQ_VALID  in  1  write request present.
- REQ_READY  out  1  block can accept a request.
- REQ_ADDR  in  ADDR_W  target word.
- REQ_DATA  in  DATA_W  value to store.
- S  out  WORDS*DATA_W  set lines; bit [a*DATA_W+i] drives latch i of word a.
- R  out  WORDS*DATA_W  reset lines; same indexing as S.
- Q  in  WORDS*DATA_W  latch outputs from the array; same indexing.
- DONE  out  1  one-cycle pulse marking write completion.
- ERR  out  1  valid only while DONE=1; 1 = readback mismatch.

## Operation

- States: IDLE, PULSE, SETTLE, VERIFY. A 4-bit down-counter serves PULSE and SETTLE.
- IDLE: REQ_READY=1, S=R=0. On REQ_VALID=1 at an edge:
  - latch REQ_ADDR and REQ_DATA into internal registers;
  - load the counter with PULSE_CYC-1;
  - go to PULSE.
- PULSE: REQ_READY=0.
  - Addressed slice: S = latched data, R = ~latched data. All other slices are 0.
  - When the counter is 0, load SETTLE_CYC-1 and go to SETTLE. Otherwise decrement.
- SETTLE: S=R=0 on all bits. When the counter is 0, go to VERIFY. Otherwise decrement.
- VERIFY (one cycle): S=R=0, DONE=1. ERR = (Q slice of latched addr != latched data), evaluated combinationally from Q in this cycle. Next state is IDLE.
- Invariant, every cycle including reset: (S & R) == 0 bitwise. At most one word slice is non-zero.
- Requests are never queued. While busy, REQ_VALID is ignored and no state is captured.
- REQ_ADDR and REQ_DATA are sampled only in the accept cycle. Later changes have no effect.
- Q is ignored outside VERIFY.
- All WORDS addresses are legal; there is no out-of-range case.

## Timing

- Reset values: state=IDLE, REQ_READY=1, S=0, R=0, DONE=0, ERR=0, counter=0, internal addr/data=0.
- S, R, REQ_READY and DONE decode from registered state only. They carry no combinational path from REQ_*.
- Accept edge E0 is the edge where REQ_VALID=1 in IDLE.
  - Cycles E0+1..E0+PULSE_CYC: S/R active.
  - Next SETTLE_CYC cycles: all-zero.
  - Following cycle: DONE=1.
  - Next cycle: IDLE, REQ_READY=1.
- Busy window is PULSE_CYC+SETTLE_CYC+1 cycles (defaults: 4). Back-to-back throughput is one write per PULSE_CYC+SETTLE_CYC+2 cycles.
- RST=1 at any edge, including mid-PULSE: next cycle is IDLE, S=R=0, DONE=0. The aborted write produces no DONE. Whether the latches were partially written is undefined.
- RST has priority over a simultaneous REQ_VALID.

## Test plan

- Reset: RST=1 for 2 cycles with REQ_VALID=1. Required: REQ_READY=1 and S=R=DONE=ERR=0 throughout, with no request accepted.
- Basic write, bench Q from sr_latch instances: write addr=1, data=4'hA.
  - S[7:4]=1010 and R[7:4]=0101 for exactly 2 cycles;
  - all other S/R bits are 0;
  - 1 all-zero cycle follows;
  - DONE=1 with ERR=0 in cycle 4;
  - REQ_READY=1 in cycle 5.
- Overwrite and hold: write addr=1 data=4'h5, then addr=2 data=4'hF. Required: Q[7:4]=0101 and Q[11:8]=1111, and both DONE pulses have ERR=0.
- Busy lockout: hold REQ_VALID=1 continuously with REQ_DATA changing every cycle. Required:
  - one accept per 5 cycles;
  - each write uses the data present at its accept edge;
  - S&R==0 checked every cycle.
- Mismatch: the bench forces Q[3:0]=0000 during a write of addr=0 data=4'h3. Required: DONE=1 with ERR=1 in VERIFY.
- Reset mid-operation: assert RST in the 2nd PULSE cycle. Required: next cycle is S=R=0 and REQ_READY=1, with no DONE afterwards. A subsequent write of addr=3 data=4'h9 completes normally.
